// File: rtl/registro_ctrl_if.sv
// registro_ctrl_if
//   Command handshake and register-drive bundle for registro_ctrl.
//   master : host side (drives CMD_*, observes READY/status/REG_*)
//   slave  : controller side (consumes CMD_*, drives READY/status/REG_*)
//   Signals:
//     CMD_VALID/CMD_READY          command handshake
//     CMD_OP/DIR/FILL/COUNT/DATA   command fields
//     REG_ENB/MODO/DIR/S_IN/D      drive to the registro datapath
//     BUSY/DONE/ERR                status
interface registro_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic             CMD_DIR;
    logic             CMD_FILL;
    logic [CNT_W-1:0] CMD_COUNT;
    logic [WIDTH-1:0] CMD_DATA;
    logic             REG_ENB;
    logic [1:0]       REG_MODO;
    logic             REG_DIR;
    logic             REG_S_IN;
    logic [WIDTH-1:0] REG_D;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    modport master (
        output CMD_VALID, CMD_OP, CMD_DIR, CMD_FILL, CMD_COUNT, CMD_DATA,
        input  CMD_READY, REG_ENB, REG_MODO, REG_DIR, REG_S_IN, REG_D,
               BUSY, DONE, ERR
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_DIR, CMD_FILL, CMD_COUNT, CMD_DATA,
        output CMD_READY, REG_ENB, REG_MODO, REG_DIR, REG_S_IN, REG_D,
               BUSY, DONE, ERR
    );
endinterface

// File: rtl/registro_ctrl.sv
// registro_ctrl
//   Command sequencer for the WIDTH-bit chained shift register. Takes one
//   LOAD / SHIFT k / ROTATE k command at a time, enables the register for
//   exactly the required number of clocks, then pulses DONE (with ERR for
//   the reserved opcode).
//   Ports:
//     CLK    rising-edge clock
//     RESET  asynchronous active-high reset
//     bus    registro_ctrl_if.slave (command handshake, register drive, status)
//
//   state | meaning
//   IDLE  | ready for a command (CMD_READY=1)
//   RUN   | register enabled, step counter running down
//   FIN   | DONE (and ERR) pulse, no new accept this cycle
module registro_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    registro_ctrl_if.slave  bus
);
    // Register mode encodings, matching LOAD / PUSH / CYCLE of the datapath.
    localparam logic [1:0] MODO_LOAD  = 2'b00;
    localparam logic [1:0] MODO_PUSH  = 2'b01;
    localparam logic [1:0] MODO_CYCLE = 2'b10;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SHIFT  = 2'b01;
    localparam logic [1:0] OP_ROTATE = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_eff;
    logic [1:0]       op_modo;
    logic             reg_enb;
    logic [1:0]       reg_modo;
    logic             reg_dir;
    logic             reg_s_in;
    logic [WIDTH-1:0] reg_d;
    logic             done;
    logic             err;

    // Effective step count and mode for the command currently offered.
    always_comb begin
        n_eff   = '0;
        op_modo = MODO_LOAD;
        case (bus.CMD_OP)
            OP_LOAD: begin
                n_eff   = CNT_W'(1);
                op_modo = MODO_LOAD;
            end
            OP_SHIFT: begin
                n_eff   = (bus.CMD_COUNT > CNT_MAX) ? CNT_MAX : bus.CMD_COUNT;
                op_modo = MODO_PUSH;
            end
            OP_ROTATE: begin
                n_eff   = (bus.CMD_COUNT > CNT_MAX) ? CNT_MAX : bus.CMD_COUNT;
                op_modo = MODO_CYCLE;
            end
            default: begin
                n_eff   = '0;
                op_modo = MODO_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            reg_enb  <= 1'b0;
            reg_modo <= MODO_LOAD;
            reg_dir  <= 1'b0;
            reg_s_in <= 1'b0;
            reg_d    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (bus.CMD_VALID) begin
                        // Mode/direction/fill are held for the whole run.
                        reg_modo <= op_modo;
                        reg_dir  <= bus.CMD_DIR;
                        reg_s_in <= bus.CMD_FILL;
                        if (bus.CMD_OP == OP_LOAD)
                            reg_d <= bus.CMD_DATA;
                        cnt <= n_eff;
                        if (n_eff != '0) begin
                            reg_enb <= 1'b1;
                            state   <= RUN;
                        end else begin
                            // Zero-step or reserved command: straight to DONE.
                            done  <= 1'b1;
                            err   <= (bus.CMD_OP == 2'b11);
                            state <= FIN;
                        end
                    end
                end
                RUN: begin
                    // cnt holds the enabled cycles still owed, this one included.
                    if (cnt <= CNT_W'(1)) begin
                        cnt     <= '0;
                        reg_enb <= 1'b0;
                        done    <= 1'b1;
                        state   <= FIN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    reg_enb <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.CMD_READY = (state == IDLE);
    assign bus.BUSY      = (state != IDLE);
    assign bus.REG_ENB   = reg_enb;
    assign bus.REG_MODO  = reg_modo;
    assign bus.REG_DIR   = reg_dir;
    assign bus.REG_S_IN  = reg_s_in;
    assign bus.REG_D     = reg_d;
    assign bus.DONE      = done;
    assign bus.ERR       = err;
endmodule

// File: tb/tb_registro_ctrl.sv
// tb_registro_ctrl
//   Drives directed commands into registro_ctrl, models the shift register it
//   controls, and checks each completed command against hand-computed results.
module tb_registro_ctrl;
    logic CLK;
    logic RESET;
    int   cyc;
    int   n_pass;
    int   n_total;

    registro_ctrl_if #(.WIDTH(32), .CNT_W(6)) bus ();

    registro_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    localparam logic [1:0] M_LOAD  = 2'b00;
    localparam logic [1:0] M_PUSH  = 2'b01;
    localparam logic [1:0] M_CYCLE = 2'b10;

    typedef struct {
        logic [31:0] q;
        int          enb;
        logic        err;
        int          lat;
        logic [1:0]  modo;
        logic        dir;
        logic        s_in;
    } exp_t;

    exp_t sb[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Register model fed by the controller outputs.
    logic [31:0] q_model;
    always @(posedge CLK) begin
        if (bus.REG_ENB) begin
            case (bus.REG_MODO)
                M_LOAD:  q_model <= bus.REG_D;
                M_PUSH:  q_model <= bus.REG_DIR ? {bus.REG_S_IN, q_model[31:1]}
                                                : {q_model[30:0], bus.REG_S_IN};
                M_CYCLE: q_model <= bus.REG_DIR ? {q_model[0], q_model[31:1]}
                                                : {q_model[30:0], q_model[31]};
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard on every DONE.
    int   enb_cnt;
    int   since;
    logic prev_busy;
    logic ctrl_bad;
    logic ready_pend;
    exp_t cur;

    initial begin
        enb_cnt = 0; since = 0; prev_busy = 0; ctrl_bad = 0; ready_pend = 0;
    end

    always @(negedge CLK) begin
        if (RESET) begin
            enb_cnt = 0; since = 0; prev_busy = 0; ctrl_bad = 0; ready_pend = 0;
        end else begin
            if (ready_pend) begin
                check("ready_after_done", {31'b0, bus.CMD_READY}, 32'd1);
                ready_pend = 0;
            end
            if (bus.BUSY && !prev_busy) since = 1;
            else if (bus.BUSY) since++;
            prev_busy = bus.BUSY;
            if (bus.REG_ENB) begin
                enb_cnt++;
                if (sb.size() > 0) begin
                    if (bus.REG_MODO !== sb[0].modo || bus.REG_DIR !== sb[0].dir) ctrl_bad = 1;
                    if (sb[0].modo == M_PUSH && bus.REG_S_IN !== sb[0].s_in) ctrl_bad = 1;
                end
            end
            if (bus.ERR && !bus.DONE) check("err_without_done", {31'b0, bus.DONE}, 32'd1);
            if (bus.DONE) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check("q_value", q_model, cur.q);
                    check("enb_cycles", enb_cnt, cur.enb);
                    check("err_flag", {31'b0, bus.ERR}, {31'b0, cur.err});
                    check("done_latency", since, cur.lat);
                    check("ctrl_stable", {31'b0, ctrl_bad}, 32'd0);
                end
                ready_pend = 1;
                enb_cnt    = 0;
                ctrl_bad   = 0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic dir, input logic fill,
                         input logic [5:0] count, input logic [31:0] data,
                         input bit push, input logic [31:0] exp_q, input int exp_enb,
                         input logic exp_err, input logic [1:0] exp_modo,
                         output int acc_cyc);
        exp_t e;
        int   guard;
        if (push) begin
            e.q = exp_q; e.enb = exp_enb; e.err = exp_err; e.lat = exp_enb + 1;
            e.modo = exp_modo; e.dir = dir; e.s_in = fill;
            sb.push_back(e);
        end
        bus.CMD_OP    = op;
        bus.CMD_DIR   = dir;
        bus.CMD_FILL  = fill;
        bus.CMD_COUNT = count;
        bus.CMD_DATA  = data;
        bus.CMD_VALID = 1'b1;
        guard = 0;
        while (!bus.CMD_READY && guard < 500) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (!bus.CMD_READY) check("ready_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        acc_cyc = cyc;
        #1;
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || !bus.CMD_READY) && guard < 500) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        n_pass = 0; n_total = 0;
        RESET = 1'b1;
        bus.CMD_VALID = 1'b0; bus.CMD_OP = 2'b00; bus.CMD_DIR = 1'b0;
        bus.CMD_FILL = 1'b0; bus.CMD_COUNT = '0; bus.CMD_DATA = '0;
        #2;
        check("rst_ready", {31'b0, bus.CMD_READY}, 32'd1);
        check("rst_enb",   {31'b0, bus.REG_ENB}, 32'd0);
        check("rst_busy",  {31'b0, bus.BUSY}, 32'd0);
        check("rst_done",  {31'b0, bus.DONE}, 32'd0);
        check("rst_err",   {31'b0, bus.ERR}, 32'd0);
        check("rst_d",     bus.REG_D, 32'h0);
        check("rst_modo",  {30'b0, bus.REG_MODO}, {30'b0, M_LOAD});
        check("rst_dir_sin", {30'b0, bus.REG_DIR, bus.REG_S_IN}, 32'd0);
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b0;
        @(posedge CLK); #1;

        // LOAD, then shifts
        issue(2'b00, 1'b0, 1'b0, 6'd0, 32'hDDDDDDDD, 1, 32'hDDDDDDDD, 1, 1'b0, M_LOAD, a1);
        issue(2'b01, 1'b0, 1'b0, 6'd4, 32'h0, 1, 32'hDDDDDDD0, 4, 1'b0, M_PUSH, a1);
        issue(2'b01, 1'b1, 1'b1, 6'd8, 32'h0, 1, 32'hFFDDDDDD, 8, 1'b0, M_PUSH, a1);
        wait_idle();

        // Rotates, clamping, zero count
        issue(2'b00, 1'b0, 1'b0, 6'd0, 32'h66666666, 1, 32'h66666666, 1, 1'b0, M_LOAD, a1);
        issue(2'b10, 1'b1, 1'b0, 6'd32, 32'h0, 1, 32'h66666666, 32, 1'b0, M_CYCLE, a1);
        issue(2'b10, 1'b1, 1'b0, 6'd40, 32'h0, 1, 32'h66666666, 32, 1'b0, M_CYCLE, a1);
        issue(2'b10, 1'b1, 1'b0, 6'd0, 32'h0, 1, 32'h66666666, 0, 1'b0, M_CYCLE, a1);
        issue(2'b00, 1'b0, 1'b0, 6'd0, 32'h12345678, 1, 32'h12345678, 1, 1'b0, M_LOAD, a1);
        issue(2'b10, 1'b0, 1'b0, 6'd4, 32'h0, 1, 32'h23456781, 4, 1'b0, M_CYCLE, a1);
        issue(2'b10, 1'b1, 1'b0, 6'd8, 32'h0, 1, 32'h81234567, 8, 1'b0, M_CYCLE, a1);
        wait_idle();

        // Abort a rotate with reset after three enabled cycles
        issue(2'b00, 1'b0, 1'b0, 6'd0, 32'h66666666, 1, 32'h66666666, 1, 1'b0, M_LOAD, a1);
        wait_idle();
        issue(2'b10, 1'b0, 1'b0, 6'd16, 32'h0, 0, 32'h0, 0, 1'b0, M_CYCLE, a1);
        repeat (3) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("abort_enb",   {31'b0, bus.REG_ENB}, 32'd0);
        check("abort_ready", {31'b0, bus.CMD_READY}, 32'd1);
        check("abort_busy",  {31'b0, bus.BUSY}, 32'd0);
        check("abort_done",  {31'b0, bus.DONE}, 32'd0);
        check("abort_d",     bus.REG_D, 32'h0);
        check("abort_q",     q_model, 32'h33333333);
        @(posedge CLK);
        #3 RESET = 1'b0;
        @(posedge CLK); #1;

        // Command held valid through a busy period, then reserved opcode
        issue(2'b00, 1'b0, 1'b0, 6'd0, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 1'b0, M_LOAD, a1);
        issue(2'b01, 1'b0, 1'b1, 6'd1, 32'h0, 1, 32'h4B4B4B4B, 1, 1'b0, M_PUSH, a2);
        check("held_accept_gap", a2 - a1, 32'd3);
        issue(2'b11, 1'b0, 1'b0, 6'd5, 32'h0, 1, 32'h4B4B4B4B, 0, 1'b1, M_LOAD, a1);
        wait_idle();
        repeat (3) @(posedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
